// File: rtl/md_hilo_unit_pkg.sv
// Shared types and op-class helpers for the multiply/divide HI/LO unit.
// Op encodings are fixed at 4 bits to match the per-slot req_op fields.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MUL   = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_DIV   = 4'd8,
        OP_DIVU  = 4'd9,
        OP_MTHI  = 4'd10,
        OP_MTLO  = 4'd11
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    function automatic logic is_mul(input md_op_t op);
        return (op == OP_MULT)  || (op == OP_MULTU) || (op == OP_MUL) ||
               (op == OP_MADD)  || (op == OP_MADDU) ||
               (op == OP_MSUB)  || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_hilo_only(input md_op_t op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    function automatic logic is_signed_op(input md_op_t op);
        return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) ||
               (op == OP_MSUB) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/md_hilo_unit_div.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Sign handling and divide-by-zero fixup live in the parent FSM.
module md_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(WIDTH);
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign busy      = (cnt != '0);
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/md_hilo_unit.sv
// Shared multiply/divide unit with architectural HI/LO for the dual-issue E stage.
// Serves pending slots oldest-first, one op at a time, stalling the stage until all are served.
//
//  state | meaning
//  IDLE  | pick lowest pending slot; MTHI/MTLO finish here, long ops latch and leave
//  MUL   | product travels the MUL_LAT-deep pipe
//  DIV   | divider iterates WIDTH cycles
//  FIX   | apply result signs / divide-by-zero values
//  DONE  | write HI/LO or res_lo, mark slot served
module md_hilo_unit
    import md_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_SLOTS = 2,
    parameter int MUL_LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_kill,
    input  logic [NUM_SLOTS-1:0]       req_valid,
    input  logic [NUM_SLOTS*4-1:0]     req_op,
    input  logic [NUM_SLOTS*WIDTH-1:0] req_a,
    input  logic [NUM_SLOTS*WIDTH-1:0] req_b,
    output logic                       stall,
    output logic [NUM_SLOTS*WIDTH-1:0] res_lo,
    output logic [2*WIDTH-1:0]         hilo_out,
    output logic                       busy
);

    localparam int SW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    md_state_t state, next_state;

    logic [NUM_SLOTS-1:0] served;
    logic [NUM_SLOTS-1:0] pending;
    logic [NUM_SLOTS-1:0] cur_bit;
    logic [CW-1:0]        cnt;
    logic                 pick_found;
    logic [SW-1:0]        pick_idx;
    md_op_t               sel_op;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic                 sel_multi;
    logic                 complete_now;
    logic                 last_pending;
    logic                 accept;

    md_op_t               op_reg;
    logic [SW-1:0]        slot_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     div_q;
    logic [WIDTH-1:0]     div_r;
    logic [2*WIDTH-1:0]   hilo;
    logic [2*WIDTH-1:0]   hilo_next;
    logic [2*WIDTH-1:0]   prod_pipe [MUL_LAT];
    logic [2*WIDTH-1:0]   prod_out;

    logic                 div_start;
    logic                 div_busy;
    logic [WIDTH-1:0]     div_a_mag;
    logic [WIDTH-1:0]     div_b_mag;
    logic [WIDTH-1:0]     div_quo;
    logic [WIDTH-1:0]     div_rem;

    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic sgn);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    // Slot selection and stall; the scan runs high-to-low so the oldest pending slot wins.
    always_comb begin
        pending    = req_valid & ~served;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_found = 1'b1;
                pick_idx   = SW'(i);
            end
        end
        sel_op    = md_op_t'(req_op[int'(pick_idx)*4 +: 4]);
        sel_a     = req_a[int'(pick_idx)*WIDTH +: WIDTH];
        sel_b     = req_b[int'(pick_idx)*WIDTH +: WIDTH];
        sel_multi = is_mul(sel_op) || is_div(sel_op);

        cur_bit = '0;
        if (state == ST_DONE) cur_bit[slot_reg] = 1'b1;
        else                  cur_bit[pick_idx] = 1'b1;

        complete_now = (state == ST_DONE) ||
                       ((state == ST_IDLE) && pick_found && !sel_multi);
        last_pending = ((pending & ~cur_bit) == '0);
        stall        = !rst && !flush && (|pending) && !(complete_now && last_pending);
        accept       = (state == ST_IDLE) && pick_found && sel_multi && !flush && !rst;

        div_a_mag = (is_signed_op(sel_op) && sel_a[WIDTH-1]) ? -sel_a : sel_a;
        div_b_mag = (is_signed_op(sel_op) && sel_b[WIDTH-1]) ? -sel_b : sel_b;
        div_start = accept && is_div(sel_op);
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = is_mul(sel_op) ? ST_MUL : ST_DIV;
            ST_MUL:  if (cnt == '0) next_state = ST_DONE;
            ST_DIV:  if (cnt == '0) next_state = ST_FIX;
            ST_FIX:  next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (flush) next_state = ST_IDLE;
    end

    always_comb begin
        prod_out  = prod_pipe[MUL_LAT-1];
        hilo_next = hilo;
        case (op_reg)
            OP_MULT, OP_MULTU: hilo_next = prod_out;
            OP_MADD, OP_MADDU: hilo_next = hilo + prod_out;
            OP_MSUB, OP_MSUBU: hilo_next = hilo - prod_out;
            OP_DIV,  OP_DIVU:  hilo_next = {div_r, div_q};
            default:           hilo_next = hilo;
        endcase
    end

    // No reset: operands are stable from the cycle after accept, so the pipe is simply flushed through.
    always_ff @(posedge clk) begin
        prod_pipe[0] <= mul_full(a_reg, b_reg, is_signed_op(op_reg));
        for (int k = 1; k < MUL_LAT; k++) prod_pipe[k] <= prod_pipe[k-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            served   <= '0;
            cnt      <= '0;
            op_reg   <= OP_NOP;
            slot_reg <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            div_q    <= '0;
            div_r    <= '0;
            hilo     <= '0;
            res_lo   <= '0;
        end else if (flush) begin
            state  <= ST_IDLE;
            served <= '0;
            cnt    <= '0;
        end else begin
            state <= next_state;
            if (!stall)            served <= '0;
            else if (complete_now) served <= served | cur_bit;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg   <= sel_op;
                        slot_reg <= pick_idx;
                        a_reg    <= sel_a;
                        b_reg    <= sel_b;
                        cnt      <= is_mul(sel_op) ? CW'(MUL_LAT - 1) : CW'(WIDTH - 1);
                    end else if (pick_found && is_hilo_only(sel_op) && !wr_kill) begin
                        if (sel_op == OP_MTHI) hilo[2*WIDTH-1:WIDTH] <= sel_a;
                        else                   hilo[WIDTH-1:0]       <= sel_a;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                ST_FIX: begin
                    if (b_reg == '0) begin
                        div_q <= '1;
                        div_r <= a_reg;
                    end else begin
                        div_q <= (is_signed_op(op_reg) && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]))
                                 ? -div_quo : div_quo;
                        div_r <= (is_signed_op(op_reg) && a_reg[WIDTH-1]) ? -div_rem : div_rem;
                    end
                end
                ST_DONE: begin
                    if (op_reg == OP_MUL)
                        res_lo[int'(slot_reg)*WIDTH +: WIDTH] <= prod_out[WIDTH-1:0];
                    else if (!wr_kill)
                        hilo <= hilo_next;
                end
                default: ;
            endcase
        end
    end

    md_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (div_start),
        .dividend  (div_a_mag),
        .divisor   (div_b_mag),
        .busy      (div_busy),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign hilo_out = hilo;
    // div_busy only rises while the FSM sits in DIV, so this equals "FSM not idle".
    assign busy     = (state != ST_IDLE) | div_busy;

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed and randomized checks of md_hilo_unit against an arithmetic HI/LO model.
// Each group presents 1-2 slots, measures the stall-low cycle, then compares HI/LO and res_lo.
module tb_md_hilo_unit;
    import md_pkg::*;

    localparam int W  = 32;
    localparam int NS = 2;
    localparam int ML = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            wr_kill;
    logic [NS-1:0]   req_valid;
    logic [NS*4-1:0] req_op;
    logic [NS*W-1:0] req_a;
    logic [NS*W-1:0] req_b;
    logic            stall;
    logic [NS*W-1:0] res_lo;
    logic [2*W-1:0]  hilo_out;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] ref_hilo;
    logic [31:0] ref_res [NS];

    md_hilo_unit #(.WIDTH(W), .NUM_SLOTS(NS), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_kill(wr_kill),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .stall(stall), .res_lo(res_lo), .hilo_out(hilo_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [3:0] op);
        if (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7}) return ML + 2;
        if (op inside {4'd8, 4'd9}) return W + 3;
        return 1;
    endfunction

    // Reference semantics in plain 64-bit arithmetic.
    task automatic model(input int slot, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic kill);
        longint sa, sb, sp, up, q, r;
        logic [63:0] nh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        nh = ref_hilo;
        case (op)
            4'd1: nh = sp;
            4'd2: nh = up;
            4'd3: ref_res[slot] = sp[31:0];
            4'd4: nh = ref_hilo + sp;
            4'd5: nh = ref_hilo + up;
            4'd6: nh = ref_hilo - sp;
            4'd7: nh = ref_hilo - up;
            4'd8, 4'd9: begin
                if (b == 0) nh = {a, 32'hFFFF_FFFF};
                else begin
                    if (op == 4'd8) begin q = sa / sb; r = sa % sb; end
                    else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    nh = {r[31:0], q[31:0]};
                end
            end
            4'd10: nh = {a, ref_hilo[31:0]};
            4'd11: nh = {ref_hilo[63:32], a};
            default: ;
        endcase
        if (!kill) ref_hilo = nh;
    endtask

    // Called at posedge+1; returns at posedge+1 after the group retires.
    task automatic run_group(input string tag, input logic [1:0] v,
                             input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                             input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                             input logic kill);
        int n;
        int exp_idx;
        bit done;
        req_valid = v;
        req_op    = {op1, op0};
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        wr_kill   = kill;
        exp_idx   = (v[0] ? lat(op0) : 0) + (v[1] ? lat(op1) : 0) - 1;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (!stall) done = 1;
            else begin
                n++;
                if (n > 300) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL %s_timeout: observed stall still high expected low", tag);
                    done = 1;
                end
            end
        end
        check({tag, "_stall_low_cycle"}, 64'(n), 64'(exp_idx));
        if (v[0]) model(0, op0, a0, b0, kill);
        if (v[1]) model(1, op1, a1, b1, kill);
        @(posedge clk); #1;
        req_valid = '0;
        wr_kill   = 1'b0;
        check({tag, "_hilo"}, hilo_out, ref_hilo);
        check({tag, "_res_lo"}, res_lo, {ref_res[1], ref_res[0]});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_kill = 1'b0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        ref_hilo = '0; ref_res[0] = '0; ref_res[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_stall", 64'(stall), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_hilo", hilo_out, 64'd0);
        check("reset_res_lo", res_lo, 64'd0);
        @(posedge clk); #1;

        // MULT -3*5
        run_group("mult", 2'b01, 4'd1, 32'hFFFF_FFFD, 32'd5, 4'd0, 0, 0, 1'b0);
        check("mult_value", hilo_out, 64'hFFFF_FFFF_FFFF_FFF1);
        // DIV -7/2, DIVU 7/0
        run_group("div", 2'b01, 4'd8, 32'hFFFF_FFF9, 32'd2, 4'd0, 0, 0, 1'b0);
        check("div_value", hilo_out, 64'hFFFF_FFFF_FFFF_FFFD);
        run_group("divu0", 2'b01, 4'd9, 32'd7, 32'd0, 4'd0, 0, 0, 1'b0);
        check("divu0_value", hilo_out, 64'h0000_0007_FFFF_FFFF);
        // MTHI/MTLO pair, MADD, MSUBU
        run_group("mthi_mtlo", 2'b11, 4'd10, 32'd0, 32'd0, 4'd11, 32'd10, 32'd0, 1'b0);
        run_group("madd", 2'b01, 4'd4, 32'd3, 32'd4, 4'd0, 0, 0, 1'b0);
        check("madd_value", hilo_out, 64'd22);
        run_group("msubu", 2'b01, 4'd7, 32'd1, 32'd23, 4'd0, 0, 0, 1'b0);
        check("msubu_value", hilo_out, 64'hFFFF_FFFF_FFFF_FFFF);
        // slot0 MUL, slot1 MTLO
        run_group("mul_mtlo", 2'b11, 4'd3, 32'd6, 32'd7, 4'd11, 32'd9, 32'd0, 1'b0);
        check("mul_mtlo_res0", 64'(res_lo[31:0]), 64'd42);
        check("mul_mtlo_hilo", hilo_out, 64'hFFFF_FFFF_0000_0009);

        // Flush a DIV at cycle 10
        req_valid = 2'b01; req_op = {4'd0, 4'd8}; req_a = {32'd0, 32'd100}; req_b = {32'd0, 32'd3};
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; req_valid = '0;
        @(negedge clk);
        check("flush_stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_hilo", hilo_out, ref_hilo);
        @(posedge clk); #1;
        run_group("post_flush", 2'b01, 4'd2, 32'hFFFF_FFFF, 32'd2, 4'd0, 0, 0, 1'b0);

        // wr_kill on MULT
        run_group("kill", 2'b01, 4'd1, 32'd1234, 32'd5678, 4'd0, 0, 0, 1'b1);
        check("kill_hilo_kept", hilo_out, 64'h0000_0001_FFFF_FFFE);

        // Reset in the middle of a DIV
        req_valid = 2'b01; req_op = {4'd0, 4'd9}; req_a = {32'd0, 32'd99}; req_b = {32'd0, 32'd4};
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_hilo = '0; ref_res[0] = '0; ref_res[1] = '0;
        @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_stall", 64'(stall), 64'(0));
        check("rst_mid_hilo", hilo_out, 64'd0);
        check("rst_mid_res_lo", res_lo, 64'd0);
        @(posedge clk); #1;

        for (int g = 0; g < 40; g++) begin
            logic [1:0]  v;
            logic [3:0]  o0, o1;
            logic [31:0] x0, y0, x1, y1;
            v  = 2'($urandom_range(1, 3));
            o0 = 4'($urandom_range(0, 11));
            o1 = 4'($urandom_range(0, 11));
            x0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            x1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            y0 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            y1 = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            run_group($sformatf("rand%0d", g), v, o0, x0, y0, o1, x1, y1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
